// File: rtl/i2c_eeprom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_pkg
// Description : Shared definitions for the Avalon I2C EEPROM master:
//               sequencer state encoding, register offsets, quarter-bit
//               phase codes and register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_eeprom_pkg;

    // Transfer sequencer states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_START  = 4'd1,
        ST_DEVW   = 4'd2,
        ST_ACK1   = 4'd3,
        ST_WADDR  = 4'd4,
        ST_ACK2   = 4'd5,
        ST_WDATA  = 4'd6,
        ST_ACK3   = 4'd7,
        ST_RSTART = 4'd8,
        ST_DEVR   = 4'd9,
        ST_ACK4   = 4'd10,
        ST_RDATA  = 4'd11,
        ST_MNACK  = 4'd12,
        ST_STOP   = 4'd13
    } state_e;

    // Avalon register offsets
    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RDATA  = 2'd2;

    // Quarter-bit phases
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Register bit positions
    localparam int RNW_BIT  = 16;
    localparam int BUSY_BIT = 0;
    localparam int DONE_BIT = 1;
    localparam int NACK_BIT = 2;

    // SCL pull-down pattern for an ordinary data/ACK bit: low in Q0 and Q3,
    // released in Q1 and Q2.
    function automatic logic scl_low_for_bit(input logic [1:0] phase);
        return (phase == Q0) || (phase == Q3);
    endfunction

endpackage : i2c_eeprom_pkg
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tick_gen
// Description : Divides clk by CLK_DIV to produce one quarter-bit tick and
//               tracks the current quarter (Q0..Q3). Counter and phase are
//               held at zero while disabled so every transfer starts aligned.
// Revision    : 1.0 - initial release
// Ports       : clk      - system clock
//               reset    - synchronous active-high reset
//               en_i     - count enable (transfer in progress)
//               tick_o   - one-cycle pulse at the end of each quarter
//               phase_o  - current quarter, advances on each tick
// ============================================================================
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int               CNT_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             w_wrap;

    always_comb begin
        w_wrap  = en_i && (cnt_q == CNT_MAX);
        cnt_d   = '0;
        phase_d = 2'd0;
        if (en_i) begin
            cnt_d   = w_wrap ? '0 : cnt_q + CNT_W'(1);
            phase_d = w_wrap ? phase_q + 2'd1 : phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign tick_o  = w_wrap;
    assign phase_o = phase_q;

endmodule : i2c_tick_gen
`default_nettype wire

// File: rtl/avalon_i2c_eeprom_master.sv
`default_nettype none
// ============================================================================
// Module      : avalon_i2c_eeprom_master
// Description : Avalon-MM slave that performs single-byte random-access
//               reads and writes to an I2C serial EEPROM, acting as the bus
//               master (SCL generation, START/Sr/STOP, ACK/NACK handling).
// Revision    : 1.0 - initial release
// Ports       : clk            - system clock
//               reset          - synchronous active-high reset
//               avs_address    - register select (0 CMD, 1 STATUS, 2 RDATA)
//               avs_write      - write strobe
//               avs_writedata  - write data
//               avs_read       - read strobe
//               avs_readdata   - read data, one cycle after avs_read
//               scl_oe         - 1 pulls SCL low
//               sda_oe         - 1 pulls SDA low
//               sda_in         - synchronised SDA pad level
// ============================================================================
module avalon_i2c_eeprom_master
    import i2c_eeprom_pkg::*;
#(
    parameter int         CLK_DIV = 125,
    parameter logic [6:0] DEV_ID  = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in
);

    state_e      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        done_q, done_d;
    logic        scl_oe_q, scl_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic [31:0] readdata_q, readdata_d;

    logic        w_busy;
    logic        w_tick;
    logic [1:0]  w_phase;
    logic        w_cmd_wr;
    logic        w_q2_tick;
    logic        w_q3_tick;
    logic [7:0]  w_tx_byte;
    logic        w_tx_bit;
    logic [31:0] w_status;
    logic        w_unused_ok;

    assign w_busy      = (state_q != ST_IDLE);
    assign w_cmd_wr    = avs_write && (avs_address == REG_CMD) && !w_busy;
    assign w_q2_tick   = w_tick && (w_phase == Q2);
    assign w_q3_tick   = w_tick && (w_phase == Q3);
    assign w_unused_ok = ^avs_writedata[31:17];

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .en_i    (w_busy),
        .tick_o  (w_tick),
        .phase_o (w_phase)
    );

    // ------------------------------------------------------------------
    // Sequencer: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        nack_d  = nack_q;
        done_d  = done_q;

        if (w_cmd_wr) begin
            addr_d  = avs_writedata[7:0];
            wdata_d = avs_writedata[15:8];
            rnw_d   = avs_writedata[RNW_BIT];
            nack_d  = 1'b0;
            done_d  = 1'b0;
            bit_d   = 3'd0;
            state_d = ST_START;
        end else if (w_tick) begin
            unique case (state_q)
                ST_IDLE: ;
                ST_START: if (w_q3_tick) state_d = ST_DEVW;
                ST_RSTART: if (w_q3_tick) state_d = ST_DEVR;
                ST_DEVW, ST_WADDR, ST_WDATA, ST_DEVR: begin
                    if (w_q3_tick) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            unique case (state_q)
                                ST_DEVW:  state_d = ST_ACK1;
                                ST_WADDR: state_d = ST_ACK2;
                                ST_WDATA: state_d = ST_ACK3;
                                default:  state_d = ST_ACK4;
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_q2_tick) begin
                        rx_d = {rx_q[6:0], sda_in};
                    end
                    if (w_q3_tick) begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            // Any NACK would have diverted to STOP earlier,
                            // so a completed byte here is a good read.
                            rdata_d = rx_q;
                            state_d = ST_MNACK;
                        end
                    end
                end
                ST_ACK1, ST_ACK2, ST_ACK3, ST_ACK4: begin
                    if (w_q2_tick && sda_in) begin
                        nack_d = 1'b1;
                    end
                    if (w_q3_tick) begin
                        if (nack_q) begin
                            state_d = ST_STOP;
                        end else begin
                            unique case (state_q)
                                ST_ACK1: state_d = ST_WADDR;
                                ST_ACK2: state_d = rnw_q ? ST_RSTART : ST_WDATA;
                                ST_ACK3: state_d = ST_STOP;
                                default: state_d = ST_RDATA;
                            endcase
                        end
                    end
                end
                ST_MNACK: if (w_q3_tick) state_d = ST_STOP;
                ST_STOP: begin
                    if (w_q3_tick) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus drive for the current state/quarter (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        unique case (state_q)
            ST_DEVW:  w_tx_byte = {DEV_ID, 1'b0};
            ST_WADDR: w_tx_byte = addr_q;
            ST_WDATA: w_tx_byte = wdata_q;
            ST_DEVR:  w_tx_byte = {DEV_ID, 1'b1};
            default:  w_tx_byte = 8'h00;
        endcase
        w_tx_bit = w_tx_byte[3'd7 - bit_q];

        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            // Lines idle high already: hold released, then SDA falls in Q2.
            ST_START: begin
                scl_oe_d = (w_phase == Q3);
                sda_oe_d = w_phase[1];
            end
            // SCL is still low from the previous ACK bit; release SDA first
            // so it is high before SCL rises, then fall SDA in Q2.
            ST_RSTART: begin
                scl_oe_d = scl_low_for_bit(w_phase);
                sda_oe_d = w_phase[1];
            end
            // SDA low across the SCL rise, released in Q2 while SCL is high.
            ST_STOP: begin
                scl_oe_d = (w_phase == Q0);
                sda_oe_d = !w_phase[1];
            end
            ST_DEVW, ST_WADDR, ST_WDATA, ST_DEVR: begin
                scl_oe_d = scl_low_for_bit(w_phase);
                sda_oe_d = !w_tx_bit;
            end
            // ACKn, RDATA and MNACK leave SDA released.
            default: begin
                scl_oe_d = scl_low_for_bit(w_phase);
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Avalon read mux. CMD is write-only; a read at its offset returns
    // STATUS, so a combined read/CMD-write cycle reports pre-write status.
    // ------------------------------------------------------------------
    always_comb begin
        w_status           = 32'd0;
        w_status[BUSY_BIT] = w_busy;
        w_status[DONE_BIT] = done_q;
        w_status[NACK_BIT] = nack_q;

        readdata_d = readdata_q;
        if (avs_read) begin
            unique case (avs_address)
                REG_CMD, REG_STATUS: readdata_d = w_status;
                REG_RDATA:           readdata_d = {24'd0, rdata_q};
                default:             readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_q      <= 3'd0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            rnw_q      <= 1'b0;
            rx_q       <= 8'd0;
            rdata_q    <= 8'd0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            readdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rnw_q      <= rnw_d;
            rx_q       <= rx_d;
            rdata_q    <= rdata_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign scl_oe       = scl_oe_q;
    assign sda_oe       = sda_oe_q;

endmodule : avalon_i2c_eeprom_master
`default_nettype wire

// File: doc/avalon_i2c_eeprom_master.md
Name: avalon_i2c_eeprom_master

Overview:
- Avalon-MM slave that sequences single-byte random-access reads and writes to an external I2C serial EEPROM.
- Acts as the I2C master for the EEPROM target: generates SCL, START/repeated-START/STOP, device-ID and word-address phases, data phase and ACK/NACK handling.
- Sits between the Avalon interconnect and the open-drain I2C pad pair.

Parameters:
- CLK_DIV, 125: clk cycles per quarter SCL bit period (tick). Must be >= 2.
- DEV_ID, 7'h50: 7-bit I2C device address of the EEPROM.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avs_address  in  2  register select
- avs_write  in  1  Avalon write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  Avalon read strobe
- avs_readdata  out  32  registered read data, read latency 1, no waitrequest
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_in  in  1  sampled SDA pad level (already synchronised)

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - scl_oe = 0, sda_oe = 0 (lines released).
  - avs_readdata = 0; busy, done and nack = 0; rdata = 0; FSM in IDLE; tick counter = 0.
- Reset mid-transaction releases both lines on the next edge; no STOP is generated.
- Register map:
  - addr 0 CMD (write): [7:0] word address, [15:8] write data, [16] rnw (1 = read).
    - Accepted only when busy = 0; otherwise ignored.
    - Acceptance sets busy = 1 and clears done and nack.
  - addr 1 STATUS (read): {29'b0, nack, done, busy}.
  - addr 2 RDATA (read): {24'b0, rdata}.
  - addr 3: reads 0; writes ignored.
- avs_readdata updates the cycle after avs_read. A same-cycle read and CMD write returns the pre-write STATUS.
- Tick generator: tick pulses once every CLK_DIV cycles while busy; the counter is held at 0 in IDLE.
- Each bit is 4 ticks:
  - Q0: SCL low, drive/release SDA.
  - Q1: release SCL.
  - Q2: SCL high, sample sda_in.
  - Q3: pull SCL low.
- States: IDLE, START, DEVW, ACK1, WADDR, ACK2, WDATA, ACK3, RSTART, DEVR, ACK4, RDATA, MNACK, STOP.
- START and RSTART (4 ticks):
  - SDA released, SCL released.
  - SDA pulled low while SCL is high.
  - Then SCL pulled low.
- STOP (4 ticks):
  - SDA low, SCL released.
  - SDA released while SCL is high.
- Byte states shift MSB first, using a 3-bit bit counter that wraps 7→0 into the next state.
  - DEVW sends {DEV_ID, 0}; DEVR sends {DEV_ID, 1}.
  - RDATA samples 8 bits into rdata.
- ACKn states release SDA and sample at Q2; sample = 1 means NACK.
  - NACK sets nack = 1 and goes to STOP.
- MNACK: master releases SDA (NACK) for the bit, then STOP.
- Write path: START, DEVW, ACK1, WADDR, ACK2, WDATA, ACK3, STOP = 116 ticks.
- Read path: START, DEVW, ACK1, WADDR, ACK2, RSTART, DEVR, ACK4, RDATA, MNACK, STOP = 156 ticks.
- Completion: on the last STOP tick, busy = 0 and done = 1 on the following cycle. done is sticky until the next accepted CMD.
- rdata updates only on a successful read; it is held on NACK.
- No clock stretching support; SCL is fully master-timed.

Decomposition:
- Package i2c_eeprom_pkg:
  - FSM state encoding.
  - Register offsets (CMD = 0, STATUS = 1, RDATA = 2).
  - Phase constants Q0–Q3.
  - Bit positions for rnw, busy, done, nack.
- Sub-module i2c_tick_gen: CLK_DIV counter with enable, producing tick and a 2-bit quarter phase.

Test Plan (CLK_DIV = 4; bench uses a behavioural I2C EEPROM model at address 0x50):
- Write CMD 0x0000_A512 (write 0xA5 to address 0x12) → busy = 1 next cycle; bytes on bus are 0xA0, 0x12, 0xA5, each ACKed; busy falls after 116 ticks (464 clks); STATUS = 0x2; model mem[0x12] = 0xA5.
- Then write CMD 0x0001_0012 (read address 0x12) → bus shows 0xA0, 0x12, Sr, 0xA1, data 0xA5, master NACK, P; STATUS = 0x2; RDATA reads 0x0000_00A5.
- Model configured with address 0x51 → NACK at ACK1 → STOP follows immediately; STATUS = 0x6; RDATA unchanged; no further SCL pulses.
- CMD written while busy (e.g. 0x0000_FF00) → ignored; the in-flight transfer completes with its original bytes.
- Assert reset at the 50th tick of a read → next cycle scl_oe = 0, sda_oe = 0, STATUS = 0; a following CMD runs normally.
- Same-cycle avs_read(addr 1) and CMD write in IDLE with done = 1 → readdata = 0x2; next STATUS read = 0x1.
